// File: rtl/rc4_crack_controller_if.sv
// rc4_crack_controller_if: controller-side bundle for the phase engines, S RAM port and search status.
interface rc4_crack_controller_if;
    logic        start, abort;
    logic [23:0] key;
    logic        init_start, ksa_start, prga_start;
    logic        init_finish, ksa_finish, prga_finish;
    logic [7:0]  init_addr, ksa_addr, prga_addr;
    logic [7:0]  init_data, ksa_data, prga_data;
    logic        init_wren, ksa_wren, prga_wren;
    logic        prga_key_ok;
    logic [7:0]  s_addr, s_data;
    logic        s_wren, busy, found, fail, timeout;
    modport master (
        input  start, abort, init_finish, ksa_finish, prga_finish,
               init_addr, ksa_addr, prga_addr, init_data, ksa_data, prga_data,
               init_wren, ksa_wren, prga_wren, prga_key_ok,
        output key, init_start, ksa_start, prga_start,
               s_addr, s_data, s_wren, busy, found, fail, timeout
    );
    modport slave (
        output start, abort, init_finish, ksa_finish, prga_finish,
               init_addr, ksa_addr, prga_addr, init_data, ksa_data, prga_data,
               init_wren, ksa_wren, prga_wren, prga_key_ok,
        input  key, init_start, ksa_start, prga_start,
               s_addr, s_data, s_wren, busy, found, fail, timeout
    );
endinterface

// File: rtl/rc4_crack_controller.sv
// rc4_crack_controller: sequences S-init, KSA and PRGA per candidate key, shares the S RAM,
// and stops on a match, on exhausting the key range, or when a phase watchdog expires.
module rc4_crack_controller #(
    parameter logic [23:0] KEY_MIN = 24'h000000,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic clk,
    input logic reset,
    rc4_crack_controller_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, CHECK, FOUND, FAIL
    } state_t;
    state_t      state_q;
    logic [23:0] key_q;
    logic [12:0] wd_q;
    logic        ok_q, init_start_q, ksa_start_q, prga_start_q;
    logic        busy_q, found_q, fail_q, timeout_q;
    logic        done, expired, g_init, g_ksa, g_prga;
    assign g_init  = state_q == INIT_GO || state_q == INIT_WAIT;
    assign g_ksa   = state_q == KSA_GO || state_q == KSA_WAIT;
    assign g_prga  = state_q == PRGA_GO || state_q == PRGA_WAIT;
    assign expired = wd_q == 13'(TIMEOUT - 1);
    // only the finish of the phase currently being waited on counts
    assign done = state_q == INIT_WAIT ? bus.init_finish :
                  state_q == KSA_WAIT  ? bus.ksa_finish  :
                  state_q == PRGA_WAIT ? bus.prga_finish : 1'b0;
    always_comb begin
        bus.s_addr = g_init ? bus.init_addr : g_ksa ? bus.ksa_addr : g_prga ? bus.prga_addr : 8'd0;
        bus.s_data = g_init ? bus.init_data : g_ksa ? bus.ksa_data : g_prga ? bus.prga_data : 8'd0;
        bus.s_wren = g_init ? bus.init_wren : g_ksa ? bus.ksa_wren : g_prga ? bus.prga_wren : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= KEY_MIN;
            wd_q         <= '0;
            ok_q         <= 1'b0;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
            if (bus.abort) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                found_q   <= 1'b0;
                fail_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, FOUND, FAIL: if (bus.start) begin
                        state_q      <= INIT_GO;
                        key_q        <= KEY_MIN;
                        init_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        found_q      <= 1'b0;
                        fail_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                    end
                    INIT_GO: begin
                        wd_q    <= '0;
                        state_q <= INIT_WAIT;
                    end
                    KSA_GO: begin
                        wd_q    <= '0;
                        state_q <= KSA_WAIT;
                    end
                    PRGA_GO: begin
                        wd_q    <= '0;
                        state_q <= PRGA_WAIT;
                    end
                    INIT_WAIT, KSA_WAIT, PRGA_WAIT: begin
                        wd_q <= wd_q + 13'd1;
                        if (done) begin
                            state_q      <= state_q == INIT_WAIT ? KSA_GO : state_q == KSA_WAIT ? PRGA_GO : CHECK;
                            ksa_start_q  <= state_q == INIT_WAIT;
                            prga_start_q <= state_q == KSA_WAIT;
                            ok_q         <= bus.prga_key_ok;
                        end else if (expired) begin
                            state_q   <= FAIL;
                            busy_q    <= 1'b0;
                            fail_q    <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end
                    CHECK: if (ok_q) begin
                        state_q <= FOUND;
                        busy_q  <= 1'b0;
                        found_q <= 1'b1;
                    end else if (key_q == KEY_MAX) begin
                        state_q <= FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                    end else begin
                        state_q      <= INIT_GO;
                        key_q        <= key_q + 24'd1;
                        init_start_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.key        = key_q;
    assign bus.init_start = init_start_q;
    assign bus.ksa_start  = ksa_start_q;
    assign bus.prga_start = prga_start_q;
    assign bus.busy       = busy_q;
    assign bus.found      = found_q;
    assign bus.fail       = fail_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_rc4_crack_controller.sv
// tb_rc4_crack_controller: engine models plus an event scoreboard for start pulses and terminal verdicts.
module tb_rc4_crack_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ksa_cyc = 0;
    int   ok_key = -1;
    bit   ksa_hang = 1'b0;
    int   ph = 0;
    bit   found_p = 1'b0;
    bit   fail_p = 1'b0;
    typedef struct {int kind; logic [23:0] key; bit to;} ev_t;
    ev_t  sb[$];

    rc4_crack_controller_if bus();
    rc4_crack_controller #(.KEY_MIN(24'd0), .KEY_MAX(24'd3), .TIMEOUT(16)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] key, input bit to);
        ev_t e;
        e.kind = kind;
        e.key = key;
        e.to = to;
        sb.push_back(e);
    endtask

    task automatic push_iter(input logic [23:0] key);
        push(0, key, 1'b0);
        push(1, key, 1'b0);
        push(2, key, 1'b0);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d key=%h, required no event", kind, bus.key);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.key !== bus.key || (kind == 4 && e.to !== bus.timeout)) begin
                bad++;
                $display("FAIL event: got kind=%0d key=%h to=%0b, required kind=%0d key=%h to=%0b",
                         kind, bus.key, bus.timeout, e.kind, e.key, e.to);
            end
            if (kind == 4 && e.to) begin
                total++;
                if (cyc - ksa_cyc != 17) begin
                    bad++;
                    $display("FAIL timeout_latency: got %0d, required 17", cyc - ksa_cyc);
                end
            end
        end
    endtask

    // monitor: start pulses, verdict edges and the RAM grant, all sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.init_start) check_ev(0);
            if (bus.ksa_start) begin
                ksa_cyc = cyc;
                check_ev(1);
            end
            if (bus.prga_start) check_ev(2);
            if (bus.found && !found_p) check_ev(3);
            if (bus.fail && !fail_p) check_ev(4);
            found_p = bus.found;
            fail_p = bus.fail;
            if (!bus.busy || bus.found || bus.fail) ph = 0;
            if (bus.init_start) ph = 1;
            if (bus.ksa_start) ph = 2;
            if (bus.prga_start) ph = 3;
            chk("grant", {7'd0, bus.s_wren, bus.s_data, bus.s_addr},
                ph == 1 ? 32'h1_A1_11 : ph == 2 ? 32'h1_A2_22 : ph == 3 ? 32'h1_A3_33 : 32'h0);
            if ((ph == 1 && bus.init_finish) || (ph == 2 && bus.ksa_finish) || (ph == 3 && bus.prga_finish))
                ph = 0;
        end
    end

    initial begin
        bus.init_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.init_start) begin
                repeat (4) @(posedge clk);
                #1 bus.init_finish = 1'b1;
                @(posedge clk);
                #1 bus.init_finish = 1'b0;
            end
        end
    end

    initial begin
        bus.ksa_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ksa_start && !ksa_hang) begin
                repeat (4) @(posedge clk);
                #1 bus.ksa_finish = 1'b1;
                @(posedge clk);
                #1 bus.ksa_finish = 1'b0;
            end
        end
    end

    initial begin
        bus.prga_finish = 1'b0;
        bus.prga_key_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.prga_start) begin
                repeat (4) @(posedge clk);
                #1;
                bus.prga_finish = 1'b1;
                bus.prga_key_ok = ok_key >= 0 && bus.key == 24'(ok_key);
                @(posedge clk);
                #1;
                bus.prga_finish = 1'b0;
                bus.prga_key_ok = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.init_addr = 8'h11; bus.init_data = 8'hA1; bus.init_wren = 1'b1;
        bus.ksa_addr  = 8'h22; bus.ksa_data  = 8'hA2; bus.ksa_wren  = 1'b1;
        bus.prga_addr = 8'h33; bus.prga_data = 8'hA3; bus.prga_wren = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_key", {8'd0, bus.key}, 32'd0);
        chk("reset_flags", {28'd0, bus.busy, bus.found, bus.fail, bus.timeout}, 32'd0);
        chk("reset_ram", {15'd0, bus.s_wren, bus.s_data, bus.s_addr}, 32'd0);

        ok_key = 2;
        for (int k = 0; k < 3; k++) push_iter(24'(k));
        push(3, 24'd2, 1'b0);
        pulse_start();
        wait_drain("found");
        repeat (10) @(negedge clk);
        chk("found_flag", {29'd0, bus.found, bus.fail, bus.busy}, 32'h4);
        chk("found_key", {8'd0, bus.key}, 32'd2);

        ok_key = -1;
        for (int k = 0; k < 4; k++) push_iter(24'(k));
        push(4, 24'd3, 1'b0);
        pulse_start();
        wait_drain("exhaust");
        repeat (5) @(negedge clk);
        chk("exhaust_flags", {28'd0, bus.found, bus.fail, bus.timeout, bus.busy}, 32'h4);
        chk("exhaust_key", {8'd0, bus.key}, 32'd3);

        ksa_hang = 1'b1;
        push(0, 24'd0, 1'b0);
        push(1, 24'd0, 1'b0);
        push(4, 24'd0, 1'b1);
        pulse_start();
        wait_drain("watchdog");
        repeat (3) @(negedge clk);
        chk("watchdog_flags", {28'd0, bus.found, bus.fail, bus.timeout, bus.busy}, 32'h6);

        ksa_hang = 1'b0;
        push_iter(24'd0);
        push(0, 24'd1, 1'b0);
        push(1, 24'd1, 1'b0);
        pulse_start();
        wait_drain("pre_abort");
        repeat (2) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_state", {28'd0, bus.busy, bus.found, bus.fail, bus.s_wren}, 32'd0);
        chk("abort_key", {8'd0, bus.key}, 32'd1);
        repeat (8) @(negedge clk);
        chk("abort_idle", {28'd0, bus.busy, bus.timeout, bus.fail, bus.s_wren}, 32'd0);

        ok_key = 0;
        push_iter(24'd0);
        push(3, 24'd0, 1'b0);
        pulse_start();
        wait_drain("restart");
        repeat (5) @(negedge clk);
        chk("restart_found", {28'd0, bus.found, bus.fail, bus.timeout, bus.busy}, 32'h8);
        chk("restart_key", {8'd0, bus.key}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
